// File: rtl/rf_ctrl_pkg.sv
// Shared constants and types for the register-file write-port arbiter and dump sequencer.
package rf_ctrl_pkg;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NREGS = 1 << AW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } dump_state_t;

    typedef struct packed {
        logic [AW-1:0] dst;
        logic [DW-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/rf_dump_seq.sv
// Register-dump sequencer: walks the debug read port over every register and streams
// the contents out one register per cycle, stalling writeback while it runs.
module rf_dump_seq
    import rf_ctrl_pkg::*;
#(
    parameter int DW    = rf_ctrl_pkg::DW,
    parameter int AW    = rf_ctrl_pkg::AW,
    parameter int NREGS = rf_ctrl_pkg::NREGS
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dump_start,
    input  logic [DW-1:0] rf_dbg_data,
    output logic          stall,
    output logic          dump_busy,
    output logic [AW-1:0] rf_dbg_addr,
    output logic          dump_valid,
    output logic [AW-1:0] dump_idx,
    output logic [DW-1:0] dump_data,
    output logic          dump_done
);

    dump_state_t   state, state_next;
    logic [AW-1:0] idx, idx_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        case (state)
            IDLE: begin
                if (dump_start) begin
                    state_next = RUN;
                    idx_next   = '0;
                end
            end
            RUN: begin
                idx_next = idx + 1'b1;
                if (idx == AW'(NREGS - 1)) state_next = DRAIN;
            end
            DRAIN:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Grants are also blocked in the IDLE cycle that launches a dump so the snapshot
    // sees every write accepted before it; reset blocks them too.
    always_comb begin
        dump_busy   = (state != IDLE);
        stall       = rst | dump_busy | (dump_start & (state == IDLE));
        rf_dbg_addr = (state == RUN) ? idx : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dump_valid <= 1'b0;
            dump_idx   <= '0;
            dump_data  <= '0;
            dump_done  <= 1'b0;
        end else begin
            dump_valid <= (state == RUN);
            dump_done  <= (state == DRAIN);
            if (state == RUN) begin
                dump_idx  <= idx;
                dump_data <= rf_dbg_data;
            end
        end
    end

endmodule

// File: rtl/rf_port_arbiter.sv
// Shares the single register-file write port between ALU (A) and load (B) writeback,
// with starvation protection for A and a coherent register-dump sequencer.
module rf_port_arbiter
    import rf_ctrl_pkg::*;
#(
    parameter int DW       = rf_ctrl_pkg::DW,
    parameter int AW       = rf_ctrl_pkg::AW,
    parameter int NREGS    = rf_ctrl_pkg::NREGS,
    parameter int MAX_WAIT = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic [AW-1:0] a_reg,
    input  logic [DW-1:0] a_data,
    input  logic          b_valid,
    output logic          b_ready,
    input  logic [AW-1:0] b_reg,
    input  logic [DW-1:0] b_data,
    output logic          rf_write,
    output logic [AW-1:0] rf_writereg,
    output logic [DW-1:0] rf_writedata,
    input  logic          dump_start,
    output logic          dump_busy,
    output logic [AW-1:0] rf_dbg_addr,
    input  logic [DW-1:0] rf_dbg_data,
    output logic          dump_valid,
    output logic [AW-1:0] dump_idx,
    output logic [DW-1:0] dump_data,
    output logic          dump_done
);

    localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    logic          stall;
    logic          a_starved;
    logic          accept;
    logic [WW-1:0] wait_cnt;
    wr_req_t       req;

    rf_dump_seq #(
        .DW   (DW),
        .AW   (AW),
        .NREGS(NREGS)
    ) u_dump_seq (
        .clk        (clk),
        .rst        (rst),
        .dump_start (dump_start),
        .rf_dbg_data(rf_dbg_data),
        .stall      (stall),
        .dump_busy  (dump_busy),
        .rf_dbg_addr(rf_dbg_addr),
        .dump_valid (dump_valid),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .dump_done  (dump_done)
    );

    always_comb begin
        a_starved = (wait_cnt == WW'(MAX_WAIT));
        a_ready   = a_valid & ~stall & (~b_valid | a_starved);
        b_ready   = b_valid & ~stall & ~a_ready;
        accept    = a_ready | b_ready;
        req.dst   = b_ready ? b_reg  : a_reg;
        req.data  = b_ready ? b_data : a_data;
    end

    // Stall cycles freeze the starvation counter rather than counting as refusals.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (!stall) begin
            if (a_valid && a_ready)           wait_cnt <= '0;
            else if (a_valid && !a_starved)   wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_write     <= 1'b0;
            rf_writereg  <= '0;
            rf_writedata <= '0;
        end else begin
            rf_write <= accept && (req.dst != '0);
            if (accept) begin
                rf_writereg  <= req.dst;
                rf_writedata <= req.data;
            end
        end
    end

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Directed-plus-random bench for rf_port_arbiter against a transaction-level model.
module tb_rf_port_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NREGS = 32;
    localparam int MW    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          a_valid = 1'b0, b_valid = 1'b0, dump_start = 1'b0;
    logic [AW-1:0] a_reg = '0, b_reg = '0;
    logic [DW-1:0] a_data = '0, b_data = '0;
    logic          a_ready, b_ready, rf_write, dump_busy, dump_valid, dump_done;
    logic [AW-1:0] rf_writereg, rf_dbg_addr, dump_idx;
    logic [DW-1:0] rf_writedata, rf_dbg_data, dump_data;

    always #5 clk = ~clk;

    rf_port_arbiter #(.DW(DW), .AW(AW), .NREGS(NREGS), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
        .rf_write(rf_write), .rf_writereg(rf_writereg), .rf_writedata(rf_writedata),
        .dump_start(dump_start), .dump_busy(dump_busy),
        .rf_dbg_addr(rf_dbg_addr), .rf_dbg_data(rf_dbg_data),
        .dump_valid(dump_valid), .dump_idx(dump_idx), .dump_data(dump_data),
        .dump_done(dump_done)
    );

    // Register file the DUT writes into and dumps from.
    logic [DW-1:0] rf [NREGS];
    logic          rf_clear = 1'b1;
    always @(posedge clk) begin
        if (rf_clear) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else if (rf_write) begin
            rf[rf_writereg] <= rf_writedata;
        end
    end
    assign rf_dbg_data = rf[rf_dbg_addr];

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [DW-1:0] exp_rf [NREGS];
    logic [DW-1:0] snap   [NREGS];
    int            refusals = 0;
    logic          pend_we = 1'b0;
    logic [AW-1:0] pend_reg = '0;
    logic [DW-1:0] pend_data = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, 64'({a_ready, b_ready, rf_write, rf_writereg, rf_writedata, dump_busy,
                        rf_dbg_addr, dump_valid, dump_idx, dump_done}), 64'd0);
        check({tag, "_dump_data"}, 64'(dump_data), 64'd0);
    endtask

    task automatic apply_reset(input string tag);
        rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1; dump_start = 1'b0;
        #1;
        check_all_zero(tag);
        @(posedge clk); #1;
        check_all_zero({tag, "_held"});
        @(negedge clk);
        rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        refusals = 0;
        pend_we  = 1'b0;
    endtask

    // One clock of stimulus; checks registered outputs from the previous cycle's
    // accept and this cycle's handshake, then advances the model.
    task automatic drive_cycle(input logic av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                               input logic bv, input logic [AW-1:0] br, input logic [DW-1:0] bd,
                               input logic ds, input logic stalled);
        logic ea, eb;
        @(negedge clk);
        check("rf_write", 64'(rf_write), 64'(pend_we));
        if (pend_we) begin
            check("rf_writereg", 64'(rf_writereg), 64'(pend_reg));
            check("rf_writedata", 64'(rf_writedata), 64'(pend_data));
        end
        a_valid = av; a_reg = ar; a_data = ad;
        b_valid = bv; b_reg = br; b_data = bd;
        dump_start = ds;
        #1;
        ea = av && !stalled && (!bv || refusals == MW);
        eb = bv && !stalled && !ea;
        check("a_ready", 64'(a_ready), 64'(ea));
        check("b_ready", 64'(b_ready), 64'(eb));
        pend_we = 1'b0;
        if (ea || eb) begin
            pend_reg  = ea ? ar : br;
            pend_data = ea ? ad : bd;
            pend_we   = (pend_reg != '0);
            if (pend_we) exp_rf[pend_reg] = pend_data;
        end
        if (ea)                                   refusals = 0;
        else if (av && !stalled && refusals < MW) refusals++;
    endtask

    task automatic idle_cycle();
        drive_cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic rand_cycle();
        drive_cycle(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
                    1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), 1'b0, 1'b0);
    endtask

    // Cycle 0 raises dump_start in IDLE; reads happen in cycles 1..32, beats appear in
    // cycles 2..33, dump_done in cycle 34. abort_c >= 0 resets the DUT in that cycle.
    task automatic run_dump(input int abort_c);
        for (int i = 0; i < NREGS; i++) snap[i] = exp_rf[i];
        for (int c = 0; c <= 34; c++) begin
            drive_cycle(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
                        1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
                        c < 20, c <= 33);
            check("dump_busy", 64'(dump_busy), 64'(c >= 1 && c <= 33));
            check("rf_dbg_addr", 64'(rf_dbg_addr), (c >= 1 && c <= 32) ? 64'(c - 1) : 64'd0);
            check("dump_valid", 64'(dump_valid), 64'(c >= 2 && c <= 33));
            if (c >= 2 && c <= 33) begin
                check("dump_idx", 64'(dump_idx), 64'(c - 2));
                check("dump_data", 64'(dump_data), 64'(snap[c - 2]));
            end
            check("dump_done", 64'(dump_done), 64'(c == 34));
            if (c == abort_c) begin
                rst = 1'b1; a_valid = 1'b1;
                #1;
                check_all_zero("abort_reset");
                @(negedge clk);
                rst = 1'b0; a_valid = 1'b0; dump_start = 1'b0;
                refusals = 0;
                pend_we  = 1'b0;
                for (int k = 0; k < 40; k++) begin
                    idle_cycle();
                    check("abort_no_done", 64'(dump_done), 64'd0);
                    check("abort_idle", 64'(dump_busy), 64'd0);
                end
                return;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NREGS; i++) exp_rf[i] = '0;

        #2;
        apply_reset("reset_initial");
        rf_clear = 1'b0;
        idle_cycle();
        idle_cycle();

        // Random traffic, then an asynchronous reset mid-run
        for (int i = 0; i < 150; i++) rand_cycle();
        idle_cycle();
        idle_cycle();
        apply_reset("reset_midrun");
        idle_cycle();

        // Single A write
        drive_cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, 1'b0, 1'b0);
        idle_cycle();

        // Both requesters on reg 7 every cycle: B,B,B,A,B,B,B,A
        for (int k = 0; k < 8; k++)
            drive_cycle(1'b1, 5'd7, 32'hA000_0000 | 32'(k), 1'b1, 5'd7, 32'hB000_0000 | 32'(k),
                        1'b0, 1'b0);
        idle_cycle();
        idle_cycle();
        check("reg7_final", 64'(rf[7]), 64'h0000_0000_A000_0007);

        // Write to register 0 is accepted but never reaches the file
        drive_cycle(1'b1, 5'd0, 32'h1234, 1'b0, '0, '0, 1'b0, 1'b0);
        idle_cycle();
        idle_cycle();
        check("reg0_untouched", 64'(rf[0]), 64'd0);

        // Preload reg i = i*3 and dump it all
        for (int i = 1; i < NREGS; i++)
            drive_cycle(1'b1, AW'(i), DW'(i * 3), 1'b0, '0, '0, 1'b0, 1'b0);
        idle_cycle();
        check("preload_reg31", 64'(exp_rf[31]), 64'd93);
        run_dump(-1);
        for (int i = 0; i < 20; i++) rand_cycle();

        // Write the cycle before dump_start must be in the snapshot; abort at beat 10
        drive_cycle(1'b1, 5'd9, 32'h0000_00AA, 1'b0, '0, '0, 1'b0, 1'b0);
        run_dump(12);

        for (int i = 0; i < 100; i++) rand_cycle();
        idle_cycle();
        idle_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
